// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM state type and JEDEC byte selection for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ        = 8'h03;
  localparam logic [7:0] CMD_JEDEC_ID    = 8'h9F;
  localparam logic [7:0] CMD_READ_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_ID,
    ST_STATUS,
    ST_IGNORE
  } state_e;

  // Byte idx of the JEDEC response, MSB byte first; past the ID the flash returns zeros.
  function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    return id[23:16];
      2'd1:    return id[15:8];
      2'd2:    return id[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus memory preload port of the flash responder.
interface spi_flash_responder_if #(
  parameter int unsigned MEM_ADDR_BITWIDTH = 16
);
  logic                         spi_clk;
  logic                         spi_cs_n;
  logic                         spi_mosi;
  logic                         spi_miso;
  logic                         mem_we;
  logic [MEM_ADDR_BITWIDTH-1:0] mem_waddr;
  logic [7:0]                   mem_wdata;
  logic                         active;
  logic                         unknown_cmd;

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi, mem_we, mem_waddr, mem_wdata,
    output spi_miso, active, unknown_cmd
  );

  modport master (
    output spi_clk, spi_cs_n, spi_mosi, mem_we, mem_waddr, mem_wdata,
    input  spi_miso, active, unknown_cmd
  );
endinterface

// File: rtl/spi_flash_responder_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with rise/fall detection.
module spi_input_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic cur_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Chain resets low so a CS held low across reset never looks like a fresh select.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= din_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = ~prev_q & cur_o;
  assign fall_o = prev_q & ~cur_o;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash responder: READ (03), JEDEC ID (9F), READ STATUS (05).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITWIDTH = 16,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter logic [23:0] JEDEC_ID          = 24'hEF4017
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_flash_responder_if.slave  bus
);

  localparam int unsigned AW = MEM_ADDR_BITWIDTH;

  logic sck_cur, sck_rise, sck_fall;
  logic cs_n_cur, cs_n_rise, cs_n_fall;
  logic mosi_cur, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .din_i(bus.spi_clk),
    .cur_o(sck_cur), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din_i(bus.spi_cs_n),
    .cur_o(cs_n_cur), .rise_o(cs_n_rise), .fall_o(cs_n_fall)
  );
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din_i(bus.spi_mosi),
    .cur_o(mosi_cur), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_sync = &{1'b0, sck_cur, cs_n_rise, cs_n_fall, mosi_rise, mosi_fall};

  state_e         state_q, state_d;
  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     tx_q, tx_d;
  logic [2:0]     tx_cnt_q, tx_cnt_d;
  logic [1:0]     ld_cnt_q, ld_cnt_d;
  logic [1:0]     id_idx_q, id_idx_d;
  logic           miso_q, miso_d;
  logic           unk_q, unk_d;
  logic           armed_q, armed_d;
  logic [7:0]     next_byte;

  logic [7:0]     mem_q [2**AW];
  logic [7:0]     mem_rdata_q;

  // Preload write and registered read; a same-address read sees the pre-write byte.
  always_ff @(posedge clk) begin
    if (bus.mem_we) begin
      mem_q[bus.mem_waddr] <= bus.mem_wdata;
    end
    mem_rdata_q <= mem_q[addr_q];
  end

  // Byte that follows the one currently in the shift register.
  always_comb begin
    next_byte = '0;
    case (state_q)
      ST_READ: next_byte = mem_rdata_q;
      ST_ID:   next_byte = jedec_byte(JEDEC_ID, id_idx_q);
      default: next_byte = '0;
    endcase
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      tx_cnt_q  <= '0;
      ld_cnt_q  <= '0;
      id_idx_q  <= '0;
      miso_q    <= 1'b0;
      unk_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      tx_cnt_q  <= tx_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      id_idx_q  <= id_idx_d;
      miso_q    <= miso_d;
      unk_q     <= unk_d;
      armed_q   <= armed_d;
    end
  end

  // Next-state and datapath decode; CS high overrides everything.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    tx_cnt_d  = tx_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    id_idx_d  = id_idx_q;
    miso_d    = miso_q;
    unk_d     = 1'b0;
    armed_d   = armed_q;

    if (cs_n_cur) begin
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      ld_cnt_d  = '0;
      id_idx_d  = '0;
      armed_d   = 1'b1;
    end else begin
      case (state_q)
        // armed_q only sets after CS is seen high, so a reset mid-frame parks here.
        ST_IDLE: begin
          miso_d = 1'b0;
          if (armed_q) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            armed_d   = 1'b0;
          end
        end
        ST_CMD: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            cmd_d = {cmd_q[6:0], mosi_cur};
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              tx_cnt_d  = '0;
              case (cmd_d)
                CMD_READ:        state_d = ST_ADDR;
                CMD_JEDEC_ID: begin
                  state_d  = ST_ID;
                  tx_d     = jedec_byte(JEDEC_ID, 2'd0);
                  id_idx_d = 2'd1;
                end
                CMD_READ_STATUS: begin
                  state_d = ST_STATUS;
                  tx_d    = 8'h00;
                end
                default: begin
                  state_d = ST_IGNORE;
                  unk_d   = 1'b1;
                end
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        // Only the low AW address bits are kept; the upper ones shift out.
        ST_ADDR: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            addr_d = {addr_q[AW-2:0], mosi_cur};
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              state_d   = ST_READ;
              ld_cnt_d  = 2'd2;
              tx_d      = '0;
              tx_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_IGNORE: miso_d = 1'b0;
        default: begin
          // ld_cnt walks the 1-cycle RAM latency: addr latched, data valid, then load
          // first byte and advance addr so the following byte is prefetched.
          if (state_q == ST_READ && ld_cnt_q != 2'd0) begin
            ld_cnt_d = ld_cnt_q - 2'd1;
            if (ld_cnt_q == 2'd1) begin
              tx_d   = mem_rdata_q;
              addr_d = addr_q + AW'(1);
            end
          end else if (sck_fall) begin
            miso_d = tx_q[7];
            if (tx_cnt_q == 3'd7) begin
              tx_d     = next_byte;
              tx_cnt_d = '0;
              if (state_q == ST_READ) addr_d = addr_q + AW'(1);
              if (state_q == ST_ID && id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              tx_cnt_d = tx_cnt_q + 3'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.active      = (state_q != ST_IDLE);
  assign bus.unknown_cmd = unk_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed and randomized bench for the SPI flash responder against a byte-level flash model.
module tb_spi_flash_responder;

  localparam int unsigned AW   = 16;
  localparam int unsigned SS   = 2;
  localparam int          HALF = 6;
  localparam logic [23:0] JID  = 24'hEF4017;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_flash_responder_if #(.MEM_ADDR_BITWIDTH(AW)) bus ();

  spi_flash_responder #(
    .MEM_ADDR_BITWIDTH(AW),
    .SYNC_STAGES(SS),
    .JEDEC_ID(JID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int unk_pulses = 0;
  logic [7:0] model_mem [int];

  always @(negedge clk) if (bus.unknown_cmd === 1'b1) unk_pulses++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int addr, input logic [7:0] data);
    bus.mem_we    = 1'b1;
    bus.mem_waddr = AW'(addr);
    bus.mem_wdata = data;
    tick(1);
    bus.mem_we    = 1'b0;
    model_mem[addr % (1 << AW)] = data;
  endtask

  // Flash as seen from the pins: memory bytes at increasing wrapped addresses,
  // the ID bytes then zeros, or an all-zero status register.
  function automatic logic [7:0] model_byte(input logic [7:0] cmd, input int unsigned addr24, input int i);
    int key;
    logic [23:0] id;
    id = JID;
    case (cmd)
      8'h03: begin
        key = int'((addr24 + i) % (1 << AW));
        return model_mem.exists(key) ? model_mem[key] : 8'hxx;
      end
      8'h9F: begin
        if (i == 0) return id[23:16];
        if (i == 1) return id[15:8];
        if (i == 2) return id[7:0];
        return 8'h00;
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = tx[7-i];
      tick(HALF);
      rx = {rx[6:0], bus.spi_miso};
      bus.spi_clk = 1'b1;
      tick(HALF);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic cs_start();
    bus.spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_end();
    bus.spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic send_header(input string tag, input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    xfer(cmd, 8, rx);
    check({tag, "_cmd_miso"}, 32'(rx), 32'h0);
    if (cmd == 8'h03) begin
      for (int b = 2; b >= 0; b--) begin
        logic [23:0] a;
        a = addr >> (8 * b);
        xfer(a[7:0], 8, rx);
        check({tag, "_addr_miso"}, 32'(rx), 32'h0);
      end
    end
  endtask

  task automatic read_txn(input string tag, input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
    logic [7:0] rx;
    cs_start();
    send_header(tag, cmd, addr);
    for (int i = 0; i < nbytes; i++) begin
      xfer(8'h00, 8, rx);
      check($sformatf("%s[%0d]", tag, i), 32'(rx), 32'(model_byte(cmd, 32'(addr), i)));
    end
    cs_end();
  endtask

  initial begin
    logic [7:0] rx;
    int n;
    bus.spi_clk   = 1'b0;
    bus.spi_cs_n  = 1'b1;
    bus.spi_mosi  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    rst = 1'b1;
    tick(3);
    check("rst_miso", 32'(bus.spi_miso), 32'h0);
    check("rst_active", 32'(bus.active), 32'h0);
    check("rst_unknown", 32'(bus.unknown_cmd), 32'h0);
    rst = 1'b0;
    tick(8);

    // Basic READ from address 0.
    preload(0, 8'hDE); preload(1, 8'hAD); preload(2, 8'hBE); preload(3, 8'hEF);
    read_txn("read0", 8'h03, 24'h000000, 4);

    // Upper address bits ignored and wrap past the top of memory.
    preload(16'hFFFE, 8'h11); preload(16'hFFFF, 8'h22); preload(0, 8'h33); preload(1, 8'h44);
    read_txn("wrap", 8'h03, 24'h7FFFFE, 4);
    preload(0, 8'hDE); preload(1, 8'hAD);

    // JEDEC ID and status.
    read_txn("jedec", 8'h9F, 24'h0, 5);
    read_txn("status", 8'h05, 24'h0, 2);

    // Abort mid-byte, then a fresh READ at 0x10.
    preload(16'h0010, 8'h5A);
    cs_start();
    send_header("abort", 8'h03, 24'h000000);
    xfer(8'h00, 5, rx);
    check("abort_5bits", 32'(rx), 32'(8'hDE >> 3));
    bus.spi_cs_n = 1'b1;
    n = 0;
    while (bus.active === 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("abort_active_drop", 32'(n <= int'(SS + 2)), 32'h1);
    tick(8);
    read_txn("after_abort", 8'h03, 24'h000010, 1);

    // Unknown opcode: one pulse, MISO held low, then normal READ.
    unk_pulses = 0;
    cs_start();
    xfer(8'hAB, 8, rx);
    check("unk_pulse", 32'(unk_pulses), 32'h1);
    check("unk_active", 32'(bus.active), 32'h1);
    xfer(8'hFF, 8, rx);
    check("unk_miso0", 32'(rx), 32'h0);
    xfer(8'hFF, 8, rx);
    check("unk_miso1", 32'(rx), 32'h0);
    cs_end();
    check("unk_pulse_total", 32'(unk_pulses), 32'h1);
    read_txn("after_unk", 8'h03, 24'h000000, 2);

    // Reset in the middle of a READ; the half-sent frame must not resume.
    cs_start();
    send_header("rstmid", 8'h03, 24'h000000);
    xfer(8'h00, 8, rx);
    check("rstmid_byte0", 32'(rx), 32'hDE);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rstmid_miso", 32'(bus.spi_miso), 32'h0);
    check("rstmid_active", 32'(bus.active), 32'h0);
    for (int i = 0; i < 2; i++) begin
      xfer(8'h00, 8, rx);
      check("rstmid_dead_byte", 32'(rx), 32'h0);
      check("rstmid_dead_active", 32'(bus.active), 32'h0);
    end
    cs_end();
    read_txn("rstmid_resume", 8'h03, 24'h000000, 1);

    // Randomized READs and unknown opcodes.
    for (int t = 0; t < 6; t++) begin
      int unsigned base;
      logic [23:0] a24;
      logic [7:0] op;
      base = $urandom_range(0, (1 << AW) - 1);
      a24  = {8'($urandom_range(0, 255)), 16'(base)};
      for (int i = 0; i < 4; i++) preload(int'((base + i) % (1 << AW)), 8'($urandom));
      read_txn($sformatf("rnd%0d", t), 8'h03, a24, 4);
      op = 8'($urandom);
      if (op == 8'h03 || op == 8'h9F || op == 8'h05) op = 8'hAB;
      unk_pulses = 0;
      cs_start();
      xfer(op, 8, rx);
      xfer(8'hFF, 8, rx);
      check($sformatf("rnd_unk_miso%0d", t), 32'(rx), 32'h0);
      cs_end();
      check($sformatf("rnd_unk_pulse%0d", t), 32'(unk_pulses), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
